amo_unit: RTL

// - Executes RV32A read-modify-write AMOs (AMOSWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU.W) against data BRAM.
// - Sits beside the EX stage and feeds the MA stage: holds the pipeline with o_stall while it runs.
// - Returns the old memory value on o_amo_result / o_amo_write_enable; MA delays that pulse one cycle before updating MA->WB.
// - LR/SC are not handled here; this block only signals reservation invalidation.

---
 rtl/amo_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/amo_unit.sv
// amo_unit: RV32A read-modify-write AMO engine (SWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU.W).
// Runs IDLE -> READ -> WRITE against a 1-cycle-latency BRAM and stalls the pipeline for 3 cycles.
// Returns the old memory value with a one-cycle write-enable pulse and clears matching LR reservations.
// o_stall, o_misaligned and o_mem_addr (IDLE) are combinational; the rest come from registers.
// Only XLEN = 32 is supported.
module amo_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [4:0]      i_funct5,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_mem_rd_data,
  output logic            o_stall,
  output logic            o_busy,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wr_data,
  output logic [3:0]      o_mem_byte_en,
  output logic [XLEN-1:0] o_amo_result,
  output logic            o_amo_write_enable,
  output logic            o_reservation_clear,
  output logic            o_misaligned
);

  localparam int unsigned BE_W = 4;

  // AMO opcodes (instr[31:27])
  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_SWAP = 5'b00001;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [XLEN-1:0]    r_addr;
  logic [4:0]         r_funct5;
  logic [XLEN-1:0]    r_rs2;
  logic [XLEN-1:0]    r_new;
  logic [XLEN-1:0]    r_result;
  logic [BE_W-1:0]    r_byte_en;
  logic               r_write_enable;
  logic               r_reservation_clear;

  logic               w_aligned;
  logic               w_accept;
  logic               w_stall;
  logic               w_misaligned;
  logic [XLEN-1:0]    w_mem_addr;
  logic [XLEN-1:0]    w_new;
  logic               w_op_valid;

  assign w_aligned = (i_addr[1:0] == 2'b00);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and combinational control outputs
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_misaligned = 1'b0;
    w_accept     = 1'b0;
    w_mem_addr   = r_addr;
    case (r_state)
      S_IDLE: begin
        w_mem_addr = {i_addr[XLEN-1:2], 2'b00};
        if (i_start) begin
          if (w_aligned) begin
            w_stall      = 1'b1;
            w_accept     = 1'b1;
            w_next_state = S_READ;
          end else begin
            w_misaligned = 1'b1;
          end
        end
      end
      S_READ: begin
        w_stall      = 1'b1;
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        w_stall      = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Recognise the nine supported AMO opcodes; anything else leaves memory untouched
  always_comb begin
    w_op_valid = 1'b0;
    case (r_funct5)
      F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: w_op_valid = 1'b1;
      default:                          w_op_valid = 1'b0;
    endcase
  end

  // new = f(old, rs2); on ties the old value is kept, unknown ops pass old through
  always_comb begin
    w_new = i_mem_rd_data;
    case (r_funct5)
      F5_SWAP: w_new = r_rs2;
      F5_ADD:  w_new = XLEN'(i_mem_rd_data + r_rs2);
      F5_XOR:  w_new = i_mem_rd_data ^ r_rs2;
      F5_AND:  w_new = i_mem_rd_data & r_rs2;
      F5_OR:   w_new = i_mem_rd_data | r_rs2;
      F5_MIN:  w_new = ($signed(r_rs2) < $signed(i_mem_rd_data)) ? r_rs2 : i_mem_rd_data;
      F5_MAX:  w_new = ($signed(r_rs2) > $signed(i_mem_rd_data)) ? r_rs2 : i_mem_rd_data;
      F5_MINU: w_new = (r_rs2 < i_mem_rd_data) ? r_rs2 : i_mem_rd_data;
      F5_MAXU: w_new = (r_rs2 > i_mem_rd_data) ? r_rs2 : i_mem_rd_data;
      default: w_new = i_mem_rd_data;
    endcase
  end

  // Latch the request when an aligned AMO is accepted in IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_funct5 <= '0;
      r_rs2    <= '0;
    end else if (w_accept) begin
      r_addr   <= {i_addr[XLEN-1:2], 2'b00};
      r_funct5 <= i_funct5;
      r_rs2    <= i_rs2;
    end
  end

  // Capture old value and new value at the end of READ; WRITE-cycle strobes last one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result            <= '0;
      r_new               <= '0;
      r_byte_en           <= '0;
      r_write_enable      <= 1'b0;
      r_reservation_clear <= 1'b0;
    end else begin
      r_byte_en           <= '0;
      r_write_enable      <= 1'b0;
      r_reservation_clear <= 1'b0;
      if (r_state == S_READ) begin
        r_result            <= i_mem_rd_data;
        r_new               <= w_new;
        r_byte_en           <= w_op_valid ? {BE_W{1'b1}} : {BE_W{1'b0}};
        r_write_enable      <= 1'b1;
        r_reservation_clear <= 1'b1;
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted
  assign o_stall             = i_rst_n & w_stall;
  assign o_misaligned        = i_rst_n & w_misaligned;
  assign o_mem_addr          = {XLEN{i_rst_n}} & w_mem_addr;
  assign o_busy              = (r_state != S_IDLE);
  assign o_mem_wr_data       = r_new;
  assign o_mem_byte_en       = r_byte_en;
  assign o_amo_result        = r_result;
  assign o_amo_write_enable  = r_write_enable;
  assign o_reservation_clear = r_reservation_clear;

endmodule
